// File: rtl/unified_mem_arbiter_if.sv
// Bundle between the arbiter, its two requesters (IF fetch, MEM load/store) and the shared memory.
// The slave view belongs to the arbiter; the master view belongs to whoever drives requests and memory.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ready;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic              stall;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_ready, if_rdata, dm_ready, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy, stall
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_ready, if_rdata, dm_ready, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy, stall
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port fixed-latency memory between instruction fetch and data load/store,
// one transaction at a time, with data priority and a fetch anti-starvation override.
module unified_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LATENCY    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  unified_mem_arbiter_if.slave  bus
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(LATENCY - 1);
  localparam logic [STV_W-1:0] STARVE_LIM = STV_W'(STARVE_MAX);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;
  typedef enum logic {OWN_IF, OWN_DM} owner_e;

  state_e            state_q,    state_d;
  owner_e            owner_q,    owner_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic              we_q,       we_d;
  logic [DATA_W-1:0] wdata_q,    wdata_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [STV_W-1:0]  starve_q,   starve_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  logic if_pend, dm_pend, arb_point, grant_dm, grant_if;
  logic if_ready, dm_ready;

  // In RESP the served requester still holds its (now completed) request, so it is masked out.
  always_comb begin
    if_pend   = bus.if_req;
    dm_pend   = bus.dm_req;
    if (state_q == S_RESP) begin
      if (owner_q == OWN_DM) dm_pend = 1'b0;
      else                   if_pend = 1'b0;
    end
    arb_point = (state_q == S_IDLE) || (state_q == S_RESP);
    grant_dm  = arb_point && dm_pend && !(if_pend && (starve_q == STARVE_LIM));
    grant_if  = arb_point && if_pend && !grant_dm;
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    wait_cnt_d = wait_cnt_q;
    starve_d   = starve_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;

    unique case (state_q)
      S_IDLE, S_RESP: begin
        if (grant_dm) begin
          state_d = S_ISSUE;
          owner_d = OWN_DM;
          addr_d  = bus.dm_addr;
          we_d    = bus.dm_we;
          wdata_d = bus.dm_wdata;
        end else if (grant_if) begin
          state_d = S_ISSUE;
          owner_d = OWN_IF;
          addr_d  = bus.if_addr;
          we_d    = 1'b0;
          wdata_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d    = S_WAIT;
        wait_cnt_d = WAIT_LOAD;
      end
      S_WAIT: begin
        if (wait_cnt_q == '0) begin
          state_d = S_RESP;
          if (owner_q == OWN_DM) dm_rdata_d = bus.mem_rdata;
          else                   if_rdata_d = bus.mem_rdata;
        end else begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Counts data grants that overtook a waiting fetch; a fetch grant resets the tally.
    if (grant_if) begin
      starve_d = '0;
    end else if (grant_dm && if_pend && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      owner_q    <= OWN_IF;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      wait_cnt_q <= '0;
      starve_q   <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      wait_cnt_q <= wait_cnt_d;
      starve_q   <= starve_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign if_ready = (state_q == S_RESP) && (owner_q == OWN_IF);
  assign dm_ready = (state_q == S_RESP) && (owner_q == OWN_DM);

  assign bus.if_ready  = if_ready;
  assign bus.dm_ready  = dm_ready;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.mem_en    = (state_q == S_ISSUE);
  assign bus.mem_we    = (state_q == S_ISSUE) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.stall     = (bus.if_req && !if_ready) || (bus.dm_req && !dm_ready);

endmodule
